// File: rtl/control_alarma.sv
// control_alarma -- mode control, manual time setting and alarm sequencing for
// a BCD wall clock.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high
//   boton_modo   push-button: step through RELOJ -> AJ_HORA -> AJ_ALARMA
//   pulm, pulh   push-buttons: minute / hour step
//   pul_apagar   push-button: snooze while ringing, stop while snoozed
//   alarma_en    alarm enable level
//   c0..c3       current time in BCD (min units, min tens, hour units, hour tens)
//   tick_min     one-cycle minute pulse to the clock counter
//   inc_min      one-cycle manual minute step to the clock counter
//   inc_hora     one-cycle manual hour step to the clock counter
//   sel_manual   1 while the clock counter is in manual-set mode (AJ_HORA)
//   a0..a3       alarm time in BCD, same digit order as c0..c3
//   modo         current mode (00 RELOJ, 01 AJ_HORA, 10 AJ_ALARMA)
//   sonar        buzzer drive
//   estado       alarm FSM state (00 INACTIVA, 01 SONANDO, 10 POSPUESTA)
//
// Pulse semantics: every button action and every output strobe (tick_min,
// inc_min, inc_hora) is a single-cycle pulse with no acknowledge; a consumer
// must act on the cycle the pulse is high. A button held down yields exactly
// one action, taken at the third rising edge after the pin is first sampled 1.

module control_alarma #(
  parameter int DIV_MIN    = 3000,
  parameter int RING_MIN   = 5,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_modo,
  input  logic       pulm,
  input  logic       pulh,
  input  logic       pul_apagar,
  input  logic       alarma_en,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  output logic       tick_min,
  output logic       inc_min,
  output logic       inc_hora,
  output logic       sel_manual,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] a3,
  output logic [1:0] modo,
  output logic       sonar,
  output logic [1:0] estado
);

  // Mode encodings
  localparam logic [1:0] RELOJ     = 2'b00;
  localparam logic [1:0] AJ_HORA   = 2'b01;
  localparam logic [1:0] AJ_ALARMA = 2'b10;

  // Alarm FSM encodings
  localparam logic [1:0] INACTIVA  = 2'b00;
  localparam logic [1:0] SONANDO   = 2'b01;
  localparam logic [1:0] POSPUESTA = 2'b10;

  // Prescaler sized to hold DIV_MIN-1
  localparam int            PW        = (DIV_MIN > 1) ? $clog2(DIV_MIN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_MIN - 1);

  // Minute counters for ringing and snoozing
  localparam int            CW          = 16;
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_MIN);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_MIN);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [7:0]    SNOOZE_LIM  = 8'(MAX_SNOOZE);

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-FF synchronizer followed by a rising-edge detector.
  // Bit order: 0 boton_modo, 1 pulm, 2 pulh, 3 pul_apagar.
  // ---------------------------------------------------------------------------
  logic [3:0] btn;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] prev;
  logic [3:0] pulse;

  assign btn = {pul_apagar, pulh, pulm, boton_modo};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
      prev  <= 4'b0000;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

  logic ev_modo;
  logic ev_min;
  logic ev_hora;
  logic ev_apagar;

  assign ev_modo   = pulse[0];
  assign ev_min    = pulse[1];
  assign ev_hora   = pulse[2];
  assign ev_apagar = pulse[3];

  // ---------------------------------------------------------------------------
  // Mode FSM. Code 11 cannot be reached by stepping; should it ever appear it
  // falls back to RELOJ on the following edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      modo <= RELOJ;
    end else begin
      case (modo)
        RELOJ:     if (ev_modo) modo <= AJ_HORA;
        AJ_HORA:   if (ev_modo) modo <= AJ_ALARMA;
        AJ_ALARMA: if (ev_modo) modo <= RELOJ;
        default:   modo <= RELOJ;
      endcase
    end
  end

  assign sel_manual = (modo == AJ_HORA);

  // ---------------------------------------------------------------------------
  // Minute prescaler. Frozen at zero while the clock is being set by hand so
  // that the counter being edited does not advance underneath the user.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          presc_run;

  assign presc_run = (modo != AJ_HORA);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (!presc_run) begin
      presc <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick_min = presc_run && (presc == PRESC_MAX);

  // ---------------------------------------------------------------------------
  // Manual clock stepping. A minute press wins over a simultaneous hour press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_min  <= 1'b0;
      inc_hora <= 1'b0;
    end else begin
      inc_min  <= (modo == AJ_HORA) && ev_min;
      inc_hora <= (modo == AJ_HORA) && ev_hora && !ev_min;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm time registers (BCD). Minutes wrap 59->00 without touching the hour;
  // hours wrap 23->00.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a3 <= 4'd0;
      a2 <= 4'd6;
      a1 <= 4'd0;
      a0 <= 4'd0;
    end else if (modo == AJ_ALARMA) begin
      if (ev_min) begin
        if (a0 == 4'd9) begin
          a0 <= 4'd0;
          if (a1 == 4'd5) a1 <= 4'd0;
          else            a1 <= a1 + 4'd1;
        end else begin
          a0 <= a0 + 4'd1;
        end
      end else if (ev_hora) begin
        if (a3 == 4'd2 && a2 == 4'd3) begin
          a3 <= 4'd0;
          a2 <= 4'd0;
        end else if (a2 == 4'd9) begin
          a2 <= 4'd0;
          a3 <= a3 + 4'd1;
        end else begin
          a2 <= a2 + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time match. eq_d comes out of reset at 1 so that a clock already showing
  // the alarm time does not fire the alarm merely because reset was released.
  // ---------------------------------------------------------------------------
  logic eq;
  logic eq_d;
  logic match_ev;

  assign eq = ({c3, c2, c1, c0} == {a3, a2, a1, a0});

  always_ff @(posedge clk) begin
    if (reset) eq_d <= 1'b1;
    else       eq_d <= eq;
  end

  assign match_ev = eq && !eq_d && (modo != AJ_HORA);

  // ---------------------------------------------------------------------------
  // Alarm FSM. Priority: enable low > stop/snooze press > counter expiry >
  // match. Counters only move on tick_min, so the mode FSM never touches them
  // directly. sonar is a registered copy of "state is SONANDO".
  // ---------------------------------------------------------------------------
  logic [CW-1:0] ring_cnt;
  logic [CW-1:0] snooze_cnt;
  logic [7:0]    snooze_num;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= INACTIVA;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snooze_num <= 8'd0;
      sonar      <= 1'b0;
    end else begin
      sonar <= (estado == SONANDO);
      if (!alarma_en) begin
        estado <= INACTIVA;
      end else begin
        case (estado)
          INACTIVA: begin
            if (match_ev) begin
              estado     <= SONANDO;
              ring_cnt   <= RING_LOAD;
              snooze_num <= 8'd0;
            end
          end
          SONANDO: begin
            if (ev_apagar) begin
              if (snooze_num < SNOOZE_LIM) begin
                estado     <= POSPUESTA;
                snooze_cnt <= SNOOZE_LOAD;
                snooze_num <= snooze_num + 8'd1;
              end else begin
                estado <= INACTIVA;
              end
            end else if (tick_min) begin
              // A counter already at zero is treated as expiring on this tick.
              if (ring_cnt == CNT_ONE || ring_cnt == '0) begin
                ring_cnt <= '0;
                estado   <= INACTIVA;
              end else begin
                ring_cnt <= ring_cnt - CNT_ONE;
              end
            end
          end
          POSPUESTA: begin
            if (ev_apagar) begin
              estado <= INACTIVA;
            end else if (tick_min) begin
              if (snooze_cnt == CNT_ONE || snooze_cnt == '0) begin
                snooze_cnt <= '0;
                estado     <= SONANDO;
                ring_cnt   <= RING_LOAD;
              end else begin
                snooze_cnt <= snooze_cnt - CNT_ONE;
              end
            end
          end
          default: estado <= INACTIVA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_alarma.sv
// Bench for control_alarma. A fast instance (DIV_MIN=4) carries the alarm and
// button sequences; a default-parameter instance shares the inputs and covers
// the alarm-setting run where no minute tick may fall. Observable events of
// the fast instance (inc pulses, mode changes, sonar edges) are compared in
// order against an expected-event queue filled by the stimulus code.

module tb_control_alarma;

  localparam int DIV_F  = 4;
  localparam int RING_F = 4;
  localparam int SNZ_F  = 2;
  localparam int MAXS_F = 3;

  localparam logic [3:0] K_INC_MIN  = 4'd1;
  localparam logic [3:0] K_INC_HORA = 4'd2;
  localparam logic [3:0] K_MODO     = 4'd3;
  localparam logic [3:0] K_SONAR    = 4'd4;

  localparam logic [1:0] ST_INACTIVA  = 2'b00;
  localparam logic [1:0] ST_SONANDO   = 2'b01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       boton_modo, pulm, pulh, pul_apagar, alarma_en;
  logic [3:0] c0, c1, c2, c3;

  logic       f_tick, f_inc_min, f_inc_hora, f_sel, f_sonar;
  logic [3:0] f_a0, f_a1, f_a2, f_a3;
  logic [1:0] f_modo, f_estado;

  logic       s_tick, s_inc_min, s_inc_hora, s_sel, s_sonar;
  logic [3:0] s_a0, s_a1, s_a2, s_a3;
  logic [1:0] s_modo, s_estado;

  control_alarma #(
    .DIV_MIN(DIV_F), .RING_MIN(RING_F), .SNOOZE_MIN(SNZ_F), .MAX_SNOOZE(MAXS_F)
  ) dut (
    .clk(clk), .reset(reset), .boton_modo(boton_modo), .pulm(pulm), .pulh(pulh),
    .pul_apagar(pul_apagar), .alarma_en(alarma_en),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .tick_min(f_tick), .inc_min(f_inc_min), .inc_hora(f_inc_hora), .sel_manual(f_sel),
    .a0(f_a0), .a1(f_a1), .a2(f_a2), .a3(f_a3),
    .modo(f_modo), .sonar(f_sonar), .estado(f_estado)
  );

  control_alarma dut_slow (
    .clk(clk), .reset(reset), .boton_modo(boton_modo), .pulm(pulm), .pulh(pulh),
    .pul_apagar(pul_apagar), .alarma_en(alarma_en),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .tick_min(s_tick), .inc_min(s_inc_min), .inc_hora(s_inc_hora), .sel_manual(s_sel),
    .a0(s_a0), .a1(s_a1), .a2(s_a2), .a3(s_a3),
    .modo(s_modo), .sonar(s_sonar), .estado(s_estado)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       mon_en = 1'b0;
  logic [1:0] prev_modo;
  logic       prev_sonar;
  logic       slow_win = 1'b0;
  int         slow_pulses = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic sb_check(input logic [7:0] got);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %02h, required none", got);
    end else begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL sb_event: got event %02h, required %02h", got, e);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (f_inc_min)             sb_check({K_INC_MIN, 4'h0});
      if (f_inc_hora)            sb_check({K_INC_HORA, 4'h0});
      if (f_modo !== prev_modo)  sb_check({K_MODO, 2'b00, f_modo});
      if (f_sonar !== prev_sonar) sb_check({K_SONAR, 3'b000, f_sonar});
    end
    prev_modo  = f_modo;
    prev_sonar = f_sonar;
    if (slow_win && (s_tick || s_inc_min || s_inc_hora)) slow_pulses++;
  end

  // ---------------- driver tasks ----------------
  // m: bit0 boton_modo, bit1 pulm, bit2 pulh, bit3 pul_apagar
  task automatic press(input logic [3:0] m);
    @(negedge clk);
    boton_modo = m[0]; pulm = m[1]; pulh = m[2]; pul_apagar = m[3];
    repeat (4) @(negedge clk);
    boton_modo = 1'b0; pulm = 1'b0; pulh = 1'b0; pul_apagar = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
    c3 = h1; c2 = h0; c1 = m1; c0 = m0;
  endtask

  task automatic wait_sonar(input logic v, input int budget, input string name,
                            input logic [1:0] st, output int nt);
    logic hit;
    hit = 1'b0;
    nt  = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (f_estado == st && f_tick) nt++;
      if (f_sonar == v) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: sonar stayed %0b, required %0b within %0d cycles", name, !v, v, budget);
    end
  endtask

  task automatic reset_checks(input string tag);
    check_val($sformatf("%s_modo", tag), f_modo, 2'b00);
    check_val($sformatf("%s_sonar", tag), f_sonar, 1'b0);
    check_val($sformatf("%s_alarm", tag), {f_a3, f_a2, f_a1, f_a0}, 16'h0600);
    check_val($sformatf("%s_estado", tag), f_estado, ST_INACTIVA);
    check_val($sformatf("%s_sel", tag), f_sel, 1'b0);
    check_val($sformatf("%s_inc", tag), {f_inc_min, f_inc_hora}, 2'b00);
    check_val($sformatf("%s_tick", tag), f_tick, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    check_val($sformatf("%s_queue_before", tag), exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset_checks(tag);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, nt, first_tick, last_tick, gap_bad;

    reset = 1'b1;
    boton_modo = 1'b0; pulm = 1'b0; pulh = 1'b0; pul_apagar = 1'b0;
    alarma_en = 1'b0;
    set_time(4'd0, 4'd5, 4'd5, 4'd9);
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst0");
    check_val("rst0_slow_alarm", {s_a3, s_a2, s_a1, s_a0}, 16'h0600);
    check_val("rst0_slow_modo", s_modo, 2'b00);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Minute prescaler in RELOJ: from count 0, ticks after edges 3, 7, 11.
    n = 0; first_tick = -1; last_tick = -1; gap_bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (f_tick) begin
        if (first_tick < 0) first_tick = k;
        if (last_tick >= 0 && (k - last_tick) != DIV_F) gap_bad++;
        last_tick = k;
        n++;
      end
    end
    check_val("tick_count", n, 3);
    check_val("tick_first", first_tick, 3);
    check_val("tick_spacing", gap_bad, 0);

    // AJ_HORA: manual steps, prescaler frozen.
    exp_q.push_back({K_MODO, 4'h1});
    press(4'b0001);
    check_val("aj_hora_modo", f_modo, 2'b01);
    check_val("aj_hora_sel", f_sel, 1'b1);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (f_tick) n++;
    end
    check_val("aj_hora_no_tick", n, 0);
    exp_q.push_back({K_INC_MIN, 4'h0});   // pulm and pulh together: minute only
    press(4'b0110);
    exp_q.push_back({K_INC_HORA, 4'h0});
    press(4'b0100);
    exp_q.push_back({K_INC_MIN, 4'h0});
    press(4'b0010);

    // AJ_ALARMA: from 06:00, 19 hour steps wrap 23->00 and land on 01;
    // 61 minute steps wrap 59->00 and land on 01.
    exp_q.push_back({K_MODO, 4'h2});
    press(4'b0001);
    check_val("aj_alarma_sel", f_sel, 1'b0);
    slow_win = 1'b1;
    repeat (19) press(4'b0100);
    repeat (61) press(4'b0010);
    slow_win = 1'b0;
    check_val("set_alarm_fast", {f_a3, f_a2, f_a1, f_a0}, 16'h0101);
    check_val("set_alarm_slow", {s_a3, s_a2, s_a1, s_a0}, 16'h0101);
    check_val("set_modo_fast", f_modo, 2'b10);
    check_val("set_modo_slow", s_modo, 2'b10);
    check_val("set_no_pulses_slow", slow_pulses, 0);
    exp_q.push_back({K_MODO, 4'h0});
    press(4'b0001);

    // Back to 06:00 through reset, then a ring left unattended.
    do_reset("rst1");
    alarma_en = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back({K_SONAR, 4'h1});
    exp_q.push_back({K_SONAR, 4'h0});
    set_time(4'd0, 4'd6, 4'd0, 4'd0);
    n = 0;
    @(posedge clk); #1;
    check_val("ring_lat_e1_sonar", f_sonar, 1'b0);
    check_val("ring_lat_e1_state", f_estado, ST_SONANDO);
    if (f_estado == ST_SONANDO && f_tick) n++;
    @(posedge clk); #1;
    check_val("ring_lat_e2_sonar", f_sonar, 1'b1);
    if (f_estado == ST_SONANDO && f_tick) n++;
    wait_sonar(1'b0, 8 * RING_F + 10, "ring_expire", ST_SONANDO, nt);
    check_val("ring_ticks", n + nt, RING_F);
    repeat (10) @(negedge clk);
    check_val("ring_done_state", f_estado, ST_INACTIVA);

    // Three snoozes, then the fourth press stops the alarm.
    set_time(4'd0, 4'd5, 4'd5, 4'd9);
    repeat (2) @(negedge clk);
    exp_q.push_back({K_SONAR, 4'h1});
    set_time(4'd0, 4'd6, 4'd0, 4'd0);
    wait_sonar(1'b1, 10, "snz_first_ring", ST_SONANDO, nt);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({K_SONAR, 4'h0});
      if (i < MAXS_F) exp_q.push_back({K_SONAR, 4'h1});
      press(4'b1000);
      check_val($sformatf("snz%0d_off", i), f_sonar, 1'b0);
      if (i < MAXS_F) wait_sonar(1'b1, 8 * SNZ_F + 10, $sformatf("snz%0d_rering", i), ST_SONANDO, nt);
    end
    check_val("snz_final_state", f_estado, ST_INACTIVA);
    repeat (30) @(negedge clk);
    check_val("snz_stays_off", {f_estado, f_sonar}, 3'b000);

    // Mode changes while ringing leave the alarm alone; then reset mid-ring.
    set_time(4'd0, 4'd5, 4'd5, 4'd9);
    repeat (2) @(negedge clk);
    exp_q.push_back({K_SONAR, 4'h1});
    set_time(4'd0, 4'd6, 4'd0, 4'd0);
    wait_sonar(1'b1, 10, "mode_ring", ST_SONANDO, nt);
    exp_q.push_back({K_MODO, 4'h1});
    press(4'b0001);
    exp_q.push_back({K_MODO, 4'h2});
    press(4'b0001);
    check_val("mode_keeps_state", f_estado, ST_SONANDO);
    check_val("mode_keeps_sonar", f_sonar, 1'b1);
    exp_q.delete();   // the reset below cuts the ring short
    do_reset("rst2");
    // Clock and alarm both read 06:00 now; no ring may start.
    repeat (10) @(negedge clk);
    check_val("post_reset_no_ring", {f_estado, f_sonar}, 3'b000);

    // Disabling the alarm wins over everything.
    set_time(4'd0, 4'd5, 4'd5, 4'd9);
    repeat (2) @(negedge clk);
    exp_q.push_back({K_SONAR, 4'h1});
    exp_q.push_back({K_SONAR, 4'h0});
    set_time(4'd0, 4'd6, 4'd0, 4'd0);
    wait_sonar(1'b1, 10, "en_ring", ST_SONANDO, nt);
    @(negedge clk);
    alarma_en = 1'b0;
    @(posedge clk); #1;
    check_val("en_off_state", f_estado, ST_INACTIVA);
    @(posedge clk); #1;
    check_val("en_off_sonar", f_sonar, 1'b0);

    repeat (4) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
